// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM state type, iteration count and the divide-by-zero LO value.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int ITER_COUNT = 32;

    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    // Signed ops are the even encodings (MULT, DIV).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Divide ops have the upper encoding bit set.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit add/subtract unit shared by the shift-add multiply and the
// restoring-divide iterations (sub_mode=1 selects x - y).
module muldiv_addsub
    import muldiv_pkg::*;
#(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub_mode,
    output logic [W-1:0] result
);

    // Single adder; subtraction folds in as x + ~y + 1.
    always_comb begin
        result = x + (sub_mode ? ~y : y) + W'(sub_mode);
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MIPS multiply/divide sequencer owning the HI/LO registers.
// One iteration per clock over a single shared 33-bit add/subtract unit.
// Define MULDIV_DIV_EN to build the divide datapath; without it DIV/DIVU
// complete immediately with HI = LO = 0.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER_COUNT);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER_COUNT - 1);

    state_e state;
    state_e next_state;

    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               sign_a;
    logic               sign_b;
    logic               dbz_r;
    logic [CW-1:0]      cnt;

    // acc_hi/acc_lo hold the partial product when multiplying and
    // remainder/quotient when dividing; mcand doubles as the divisor.
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   mcand;

    logic               is_signed;
    logic               is_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic [WIDTH:0]     add_sum;
    logic               sub_mode;

    logic [2*WIDTH-1:0] product_raw;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     div_shift;
`endif

    assign is_signed = op_is_signed(op_r);
    assign is_div    = op_is_div(op_r);
    assign mag_a     = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
    assign mag_b     = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign div_by_zero = done && dbz_r;

    muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .x        (add_x),
        .y        (add_y),
        .sub_mode (sub_mode),
        .result   (add_sum)
    );

    // Steer the shared adder: accumulate for multiply, trial-subtract
    // the divisor from the shifted remainder for divide.
    always_comb begin
        add_y = {1'b0, mcand};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        sub_mode  = is_div;
        add_x     = is_div ? div_shift : acc_hi;
`else
        sub_mode  = 1'b0;
        add_x     = acc_hi;
`endif
    end

    // Apply result signs to the unsigned magnitudes before HI/LO write.
    always_comb begin
        product_raw = {acc_hi[WIDTH-1:0], acc_lo};
        product     = (sign_a ^ sign_b) ? -product_raw : product_raw;
        fix_hi      = product[2*WIDTH-1:WIDTH];
        fix_lo      = product[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            fix_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
            fix_hi = sign_a ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush wins over everything, including start.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) next_state = S_PREP;
                S_PREP: begin
                    if (is_div) begin
`ifdef MULDIV_DIV_EN
                        next_state = (b_r == '0) ? S_DONE : S_ITER;
`else
                        next_state = S_DONE;
`endif
                    end else begin
                        next_state = S_ITER;
                    end
                end
                S_ITER: if (cnt == LAST_ITER) next_state = S_FIX;
                S_FIX:  next_state = S_DONE;
                S_DONE: next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Operand capture, iteration datapath and HI/LO writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dbz_r  <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                    end
                end
                S_PREP: begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    dbz_r  <= 1'b0;
                    sign_a <= is_signed && a_r[WIDTH-1];
                    sign_b <= is_signed && b_r[WIDTH-1];
                    mcand  <= is_div ? mag_b : mag_a;
                    acc_lo <= is_div ? mag_a : mag_b;
                    if (is_div && !flush) begin
`ifdef MULDIV_DIV_EN
                        if (b_r == '0) begin
                            hi    <= a_r;
                            lo    <= DIV_ZERO_LO[WIDTH-1:0];
                            dbz_r <= 1'b1;
                        end
`else
                        hi <= '0;
                        lo <= '0;
`endif
                    end
                end
                S_ITER: begin
                    cnt <= cnt + CW'(1);
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        acc_hi <= add_sum[WIDTH] ? div_shift : add_sum;
                        acc_lo <= {acc_lo[WIDTH-2:0], ~add_sum[WIDTH]};
                    end else begin
                        {acc_hi, acc_lo} <= {(acc_lo[0] ? add_sum : acc_hi), acc_lo} >> 1;
                    end
`else
                    {acc_hi, acc_lo} <= {(acc_lo[0] ? add_sum : acc_hi), acc_lo} >> 1;
`endif
                end
                S_FIX: begin
                    if (!flush) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
